// File: rtl/gpixshift_if.sv
// Latch-stage to serializer bus: plane bytes and slot controls in, RGB pixel and ACT out.
interface gpixshift_if;
  logic [2:0] cnt;
  logic       BLANK;
  logic [7:0] ROD;
  logic [7:0] GOD;
  logic [7:0] BOD;
  logic [2:0] PEN;
  logic       MONO;
  logic       R;
  logic       G;
  logic       B;
  logic       ACT;

  modport master (
    output cnt, BLANK, ROD, GOD, BOD, PEN, MONO,
    input  R, G, B, ACT
  );

  modport slave (
    input  cnt, BLANK, ROD, GOD, BOD, PEN, MONO,
    output R, G, B, ACT
  );
endinterface

// File: rtl/gpixshift.sv
// Graphic pixel serializer: plane bytes latched in one 8-clock slot are shifted out
// one RGB pixel per clock in the next slot, with slot-aligned blank, plane enable and mono.

// One plane's shifter. pix is the raw pixel that the next edge registers:
// bit 0 of the new byte on a load edge, otherwise the output end of the shifter.
module gpixshift_lane #(
  parameter int LSB_FIRST = 1
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       load,
  input  logic [7:0] od,
  output logic       pix
);
  logic [7:0] sr;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)     sr <= '0;
        else if (load) sr <= {1'b0, od[7:1]};
        else           sr <= {1'b0, sr[7:1]};
      end
      assign pix = load ? od[0] : sr[0];
    end else begin : g_msb
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)     sr <= '0;
        else if (load) sr <= {od[6:0], 1'b0};
        else           sr <= {sr[6:0], 1'b0};
      end
      assign pix = load ? od[7] : sr[7];
    end
  endgenerate
endmodule

module gpixshift #(
  parameter int         LSB_FIRST = 1,
  parameter logic [2:0] LOAD_CNT  = 3'b111
) (
  input logic         CLK,
  input logic         nRST,
  gpixshift_if.slave  bus
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  typedef struct packed {
    logic       blank;
    logic [2:0] pen;
    logic       mono;
  } ctl_t;

  localparam ctl_t CTL_RST = '{blank: 1'b1, pen: 3'b000, mono: 1'b0};

  logic                              load;
  logic [NUM_LANES-1:0][VEC_W-1:0]   od;
  logic [NUM_LANES-1:0]              raw;
  logic [NUM_LANES-1:0]              masked;
  logic [NUM_LANES-1:0]              pix_n;
  logic [NUM_LANES-1:0]              pix_q;
  logic                              act_q;
  ctl_t                              ctl_q;
  ctl_t                              ctl_n;

  assign load = (bus.cnt == LOAD_CNT);
  assign od   = {bus.BOD, bus.GOD, bus.ROD};

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      gpixshift_lane #(.LSB_FIRST(LSB_FIRST)) u_lane (
        .CLK  (CLK),
        .nRST (nRST),
        .load (load),
        .od   (od[i]),
        .pix  (raw[i])
      );
    end
  endgenerate

  // Pixel 0 must see the controls sampled on its own load edge, so the output
  // function uses the next-state controls rather than the registered ones.
  always_comb begin
    ctl_n = ctl_q;
    if (load) ctl_n = '{blank: bus.BLANK, pen: bus.PEN, mono: bus.MONO};
  end

  always_comb begin
    masked = raw & ctl_n.pen;
    pix_n  = masked;
    if (ctl_n.mono)  pix_n = {NUM_LANES{|masked}};
    if (ctl_n.blank) pix_n = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctl_q <= CTL_RST;
      pix_q <= '0;
      act_q <= 1'b0;
    end else begin
      ctl_q <= ctl_n;
      pix_q <= pix_n;
      act_q <= ~ctl_n.blank;
    end
  end

  assign bus.R   = pix_q[0];
  assign bus.G   = pix_q[1];
  assign bus.B   = pix_q[2];
  assign bus.ACT = act_q;
endmodule

// File: tb/tb_gpixshift.sv
// Directed bench for gpixshift: LSB-first and MSB-first instances share one stimulus stream.
`timescale 1ns/1ps
module tb_gpixshift;
  logic CLK;
  logic nRST;
  int   n_pass;
  int   n_total;

  gpixshift_if bus0();
  gpixshift_if bus1();

  assign bus1.cnt   = bus0.cnt;
  assign bus1.BLANK = bus0.BLANK;
  assign bus1.ROD   = bus0.ROD;
  assign bus1.GOD   = bus0.GOD;
  assign bus1.BOD   = bus0.BOD;
  assign bus1.PEN   = bus0.PEN;
  assign bus1.MONO  = bus0.MONO;

  gpixshift #(.LSB_FIRST(1), .LOAD_CNT(3'b111)) u_lsb (.CLK(CLK), .nRST(nRST), .bus(bus0.slave));
  gpixshift #(.LSB_FIRST(0), .LOAD_CNT(3'b111)) u_msb (.CLK(CLK), .nRST(nRST), .bus(bus1.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit         sel;
    logic [7:0] rod, god, bod;
    logic [2:0] pen;
    logic       mono, blank;
    logic [7:0] er, eg, eb;
    logic       eact;
  } vec_t;

  vec_t vt[8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h", nm, got, exp);
    else n_pass++;
  endtask

  task automatic set_in(input logic [7:0] r, g, b, input logic [2:0] pen,
                        input logic mono, blank);
    bus0.ROD = r; bus0.GOD = g; bus0.BOD = b;
    bus0.PEN = pen; bus0.MONO = mono; bus0.BLANK = blank;
  endtask

  task automatic sample(input bit sel, output logic r, g, b, a);
    if (sel) begin r = bus1.R; g = bus1.G; b = bus1.B; a = bus1.ACT; end
    else     begin r = bus0.R; g = bus0.G; b = bus0.B; a = bus0.ACT; end
  endtask

  // One full slot: load edge (cnt=7) then cnt=0..6. Bit k of each result is pixel k.
  // With scramble, every input is inverted right after the load edge.
  task automatic run_slot(input bit sel, input bit scramble,
                          output logic [7:0] rs, gs, bs, as);
    logic r, g, b, a;
    for (int k = 0; k < 8; k++) begin
      bus0.cnt = (k == 0) ? 3'd7 : 3'(k - 1);
      tick();
      sample(sel, r, g, b, a);
      rs[k] = r; gs[k] = g; bs[k] = b; as[k] = a;
      if (k == 0 && scramble)
        set_in(~bus0.ROD, ~bus0.GOD, ~bus0.BOD, ~bus0.PEN, ~bus0.MONO, ~bus0.BLANK);
    end
  endtask

  // After reset release: cnt=0..6 stays black/inactive, then the first load shows pixel 0.
  task automatic post_reset(input string nm);
    logic [7:0] acc;
    acc = '0;
    set_in(8'hFF, 8'h00, 8'h00, 3'b111, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      bus0.cnt = 3'(k);
      tick();
      acc[k] = bus0.R | bus0.G | bus0.B | bus0.ACT | bus1.R | bus1.ACT;
    end
    chk({nm, "_preload_zero"}, {8'h0, acc}, 16'h0);
    bus0.cnt = 3'd7;
    tick();
    chk({nm, "_first_R"},   {15'h0, bus0.R}, 16'h1);
    chk({nm, "_first_ACT"}, {15'h0, bus0.ACT}, 16'h1);
  endtask

  initial begin
    logic [7:0]  rs, gs, bs, as;
    logic [11:0] seq, aseq;
    logic        acc;
    n_pass = 0; n_total = 0;

    vt[0] = '{0, 8'hA5, 8'h0F, 8'hF0, 3'b111, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hF0, 1'b1};
    vt[1] = '{0, 8'hA5, 8'h0F, 8'hF0, 3'b001, 1'b1, 1'b0, 8'hA5, 8'hA5, 8'hA5, 1'b1};
    vt[2] = '{0, 8'hA5, 8'h0F, 8'hF0, 3'b000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
    vt[3] = '{0, 8'hA5, 8'h0F, 8'hF0, 3'b111, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vt[4] = '{0, 8'hA5, 8'h0F, 8'hF0, 3'b010, 1'b0, 1'b0, 8'h00, 8'h0F, 8'h00, 1'b1};
    vt[5] = '{0, 8'hA5, 8'h0F, 8'hF0, 3'b110, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1};
    vt[6] = '{1, 8'hA5, 8'h0F, 8'hF0, 3'b111, 1'b0, 1'b0, 8'hA5, 8'hF0, 8'h0F, 1'b1};
    vt[7] = '{1, 8'h80, 8'h01, 8'h00, 3'b111, 1'b0, 1'b0, 8'h01, 8'h80, 8'h00, 1'b1};

    // Reset held with live data and a running counter.
    nRST = 1'b0;
    bus0.cnt = 3'd0;
    set_in(8'hFF, 8'hFF, 8'hFF, 3'b111, 1'b0, 1'b0);
    #1;
    acc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus0.cnt = 3'(k + 3);
      tick();
      acc = acc | bus0.R | bus0.G | bus0.B | bus0.ACT | bus1.R | bus1.G | bus1.B | bus1.ACT;
    end
    chk("reset_hold_zero", {15'h0, acc}, 16'h0);
    nRST = 1'b1;
    post_reset("rst");

    // Table-driven slots; inputs are inverted mid-slot to show they only matter at load.
    for (int v = 0; v < 8; v++) begin
      set_in(vt[v].rod, vt[v].god, vt[v].bod, vt[v].pen, vt[v].mono, vt[v].blank);
      run_slot(vt[v].sel, 1'b1, rs, gs, bs, as);
      chk($sformatf("vec%0d_R", v),   {8'h0, rs}, {8'h0, vt[v].er});
      chk($sformatf("vec%0d_G", v),   {8'h0, gs}, {8'h0, vt[v].eg});
      chk($sformatf("vec%0d_B", v),   {8'h0, bs}, {8'h0, vt[v].eb});
      chk($sformatf("vec%0d_ACT", v), {8'h0, as}, {8'h0, {8{vt[v].eact}}});
    end

    // Blank alignment: BLANK rising mid-slot only takes effect at the next load.
    set_in(8'hFF, 8'h00, 8'h00, 3'b111, 1'b0, 1'b0);
    run_slot(0, 1'b1, rs, gs, bs, as);
    chk("blank_a_R",   {8'h0, rs}, 16'h00FF);
    chk("blank_a_ACT", {8'h0, as}, 16'h00FF);
    set_in(8'hFF, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1);
    run_slot(0, 1'b0, rs, gs, bs, as);
    chk("blank_b_R",   {8'h0, rs}, 16'h0000);
    chk("blank_b_ACT", {8'h0, as}, 16'h0000);
    bus0.BLANK = 1'b0;
    run_slot(0, 1'b0, rs, gs, bs, as);
    chk("blank_c_R",   {8'h0, rs}, 16'h00FF);
    chk("blank_c_ACT", {8'h0, as}, 16'h00FF);

    // Missing load: cnt parked at 0 after one load drains 8 ones, then black.
    set_in(8'hFF, 8'h00, 8'h00, 3'b111, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      bus0.cnt = (k == 0) ? 3'd7 : 3'd0;
      tick();
      seq[k] = bus0.R; aseq[k] = bus0.ACT;
    end
    chk("noload_R",   {4'h0, seq},  16'h00FF);
    chk("noload_ACT", {4'h0, aseq}, 16'h0FFF);

    // Early load four edges after the previous one: new pixel 0 appears at once.
    bus0.cnt = 3'd7; tick();
    for (int k = 0; k < 3; k++) begin bus0.cnt = 3'(k); tick(); end
    bus0.ROD = 8'h06;
    run_slot(0, 1'b0, rs, gs, bs, as);
    chk("early_pix0", {15'h0, rs[0]}, 16'h0);
    chk("early_R",    {8'h0, rs},     16'h0006);

    // Reset asserted mid-slot clears outputs without a clock edge.
    set_in(8'hFF, 8'hFF, 8'hFF, 3'b111, 1'b0, 1'b0);
    bus0.cnt = 3'd7; tick();
    bus0.cnt = 3'd0; tick();
    #1 nRST = 1'b0;
    #1;
    chk("midrst_RGB", {13'h0, bus0.B, bus0.G, bus0.R}, 16'h0);
    chk("midrst_ACT", {14'h0, bus1.ACT, bus0.ACT}, 16'h0);
    tick();
    nRST = 1'b1;
    post_reset("midrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
